cntr_load_sched: RTL and testbench

CNTR_LOAD_SCHED -- requirements
Module: cntr_load_sched

---
 rtl/cntr_load_sched.sv | 167 ++++++++++++++++
 tb/tb_cntr_load_sched.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/cntr_load_sched.sv
`default_nettype none
// ============================================================================
// Module      : cntr_load_sched
// Description : Round-robin session scheduler for one shared, loadable 4-bit
//               wrap counter. Each session:
//                 - loads the winner's start value into the counter,
//                 - runs until the counter has wrapped a requested number
//                   of times,
//                 - then pulses done for that requester.
// Ports       : clk        - clock, rising edge active
//               rst_n      - asynchronous active-low reset
//               req        - per-requester session request (level)
//               req_val    - per-requester load value, 4 bits per requester
//               req_wraps  - per-requester session length in wraps (0 -> 1)
//               cnt_q      - shared counter's current count
//               cnt_ld     - load strobe to the shared counter
//               cnt_ld_val - load value to the shared counter
//               gnt        - one-hot grant, high during LOAD and RUN
//               done       - one-cycle session-complete pulse per requester
//               busy       - high whenever the scheduler is not idle
// Revision    : 1.0 - initial release
// ============================================================================
module cntr_load_sched #(
  parameter int N_REQ = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req,
  input  logic [4*N_REQ-1:0]   req_val,
  input  logic [4*N_REQ-1:0]   req_wraps,
  input  logic [3:0]           cnt_q,
  output logic                 cnt_ld,
  output logic [3:0]           cnt_ld_val,
  output logic [N_REQ-1:0]     gnt,
  output logic [N_REQ-1:0]     done,
  output logic                 busy
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t          r_state;
  logic [IW-1:0]   r_rr_ptr;
  logic [IW-1:0]   r_win;
  logic [3:0]      r_target;
  logic [4:0]      r_wrap_cnt;

  // Per-requester views of the packed value/length buses.
  logic [3:0]      w_val_arr   [N_REQ];
  logic [3:0]      w_wraps_arr [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_slice
      assign w_val_arr[gi]   = req_val[4*gi +: 4];
      assign w_wraps_arr[gi] = req_wraps[4*gi +: 4];
    end
  endgenerate

  // Round-robin pick: scan from r_rr_ptr upward (modulo N_REQ) and take the
  // first requester with req high.
  logic            w_found;
  logic [IW-1:0]   w_win;
  logic [IW-1:0]   w_idx;

  always_comb begin
    w_found = 1'b0;
    w_win   = r_rr_ptr;
    w_idx   = r_rr_ptr;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx = IW'((int'(r_rr_ptr) + k) % N_REQ);
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  logic [N_REQ-1:0] w_win_oh;
  logic [N_REQ-1:0] w_cur_oh;
  logic [3:0]       w_new_target;
  logic             w_wrap;
  logic [4:0]       w_wrap_inc;
  logic             w_last_wrap;

  assign w_win_oh     = {{(N_REQ-1){1'b0}}, 1'b1} << w_win;
  assign w_cur_oh     = {{(N_REQ-1){1'b0}}, 1'b1} << r_win;
  // A zero-length request still runs for one wrap.
  assign w_new_target = (w_wraps_arr[w_win] == 4'h0) ? 4'h1 : w_wraps_arr[w_win];
  // Every RUN cycle with the counter at F is one wrap; with a load value of F
  // the counter sits at F so every cycle counts.
  assign w_wrap       = (cnt_q == 4'hF);
  assign w_wrap_inc   = r_wrap_cnt + 5'd1;
  assign w_last_wrap  = w_wrap && (w_wrap_inc == {1'b0, r_target});

  // Single state machine; all outputs are registered and set on the edge
  // that enters the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_rr_ptr   <= '0;
      r_win      <= '0;
      r_target   <= 4'h1;
      r_wrap_cnt <= 5'd0;
      cnt_ld     <= 1'b0;
      cnt_ld_val <= 4'h0;
      gnt        <= '0;
      done       <= '0;
      busy       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_state    <= ST_LOAD;
            r_win      <= w_win;
            r_target   <= w_new_target;
            r_wrap_cnt <= 5'd0;
            cnt_ld     <= 1'b1;
            cnt_ld_val <= w_val_arr[w_win];
            gnt        <= w_win_oh;
            busy       <= 1'b1;
          end
        end

        ST_LOAD: begin
          r_state <= ST_RUN;
          cnt_ld  <= 1'b0;
        end

        ST_RUN: begin
          if (w_wrap) begin
            r_wrap_cnt <= w_wrap_inc;
            if (w_last_wrap) begin
              r_state  <= ST_DONE;
              gnt      <= '0;
              done     <= w_cur_oh;
              // Next arbitration starts just past this session's winner.
              r_rr_ptr <= (r_win == IW'(N_REQ - 1)) ? '0 : r_win + 1'b1;
            end
          end
        end

        ST_DONE: begin
          r_state <= ST_IDLE;
          done    <= '0;
          busy    <= 1'b0;
        end

        default: begin
          r_state <= ST_IDLE;
          cnt_ld  <= 1'b0;
          gnt     <= '0;
          done    <= '0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cntr_load_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_cntr_load_sched
// Description : Self-checking bench for cntr_load_sched. Hosts a model of the
//               shared wrap counter (reloads its load value after F) and a
//               session-level reference computing each session's DONE cycle
//               from the load value and wrap count in closed form.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cntr_load_sched;

  localparam int N_REQ = 4;
  localparam int VW    = 4 * N_REQ;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N_REQ-1:0]  req = '0;
  logic [VW-1:0]     req_val = '0;
  logic [VW-1:0]     req_wraps = '0;
  logic [3:0]        cnt_q = 4'h0;
  logic [3:0]        cnt_base = 4'h0;
  logic              cnt_ld;
  logic [3:0]        cnt_ld_val;
  logic [N_REQ-1:0]  gnt;
  logic [N_REQ-1:0]  done;
  logic              busy;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: session active flag, cycles since LOAD, DONE cycle index.
  bit         m_act = 1'b0;
  int         m_age = 0;
  int         m_done_at = 0;
  int         m_win = 0;
  int         m_rr = 0;
  logic [3:0] m_val = 4'h0;

  cntr_load_sched #(.N_REQ(N_REQ)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_val    (req_val),
    .req_wraps  (req_wraps),
    .cnt_q      (cnt_q),
    .cnt_ld     (cnt_ld),
    .cnt_ld_val (cnt_ld_val),
    .gnt        (gnt),
    .done       (done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Shared loadable wrap counter: after F it returns to the last load value.
  always @(posedge clk) begin
    if (cnt_ld) begin
      cnt_q    <= cnt_ld_val;
      cnt_base <= cnt_ld_val;
    end else if (cnt_q == 4'hF) begin
      cnt_q <= cnt_base;
    end else begin
      cnt_q <= cnt_q + 4'h1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_outputs();
    logic [N_REQ-1:0] eg;
    logic [N_REQ-1:0] ed;
    int vi;
    int ec;
    eg = '0;
    ed = '0;
    if (m_act && m_age < m_done_at) eg = N_REQ'(1) << m_win;
    if (m_act && m_age == m_done_at) ed = N_REQ'(1) << m_win;
    check("gnt", 32'(gnt), 32'(eg));
    check("done", 32'(done), 32'(ed));
    check("cnt_ld", 32'(cnt_ld), 32'(m_act && m_age == 0));
    check("cnt_ld_val", 32'(cnt_ld_val), 32'(m_val));
    check("busy", 32'(busy), 32'(m_act));
    check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
    if (m_act && m_age >= 1 && m_age < m_done_at) begin
      vi = int'(m_val);
      ec = vi + ((m_age - 1) % (16 - vi));
      check("cnt_q", 32'(cnt_q), 32'(ec));
    end
  endtask

  // Advance the reference by one clock edge with the inputs now applied.
  task automatic advance(input logic [N_REQ-1:0] r, input logic [VW-1:0] v, input logic [VW-1:0] w);
    int win;
    int idx;
    int kw;
    if (m_act) begin
      if (m_age == m_done_at) m_act = 1'b0;
      else m_age++;
    end else if (r != '0) begin
      win = -1;
      for (int k = 0; k < N_REQ; k++) begin
        idx = (m_rr + k) % N_REQ;
        if (win < 0 && ((r >> idx) & 1) != 0) win = idx;
      end
      m_win = win;
      m_val = 4'(v >> (4 * win));
      kw = int'(4'(w >> (4 * win)));
      if (kw == 0) kw = 1;
      // LOAD at age 0; first F after (15-val) RUN cycles, then every (16-val).
      m_done_at = 2 + (15 - int'(m_val)) + (kw - 1) * (16 - int'(m_val));
      m_age = 0;
      m_act = 1'b1;
      m_rr = (win + 1) % N_REQ;
    end
  endtask

  task automatic step(input logic [N_REQ-1:0] r, input logic [VW-1:0] v, input logic [VW-1:0] w);
    @(negedge clk);
    compare_outputs();
    req       = r;
    req_val   = v;
    req_wraps = w;
    advance(r, v, w);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic do_reset();
    @(negedge clk);
    compare_outputs();
    req = '0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_cnt_ld", 32'(cnt_ld), 32'd0);
    check("rst_cnt_ld_val", 32'(cnt_ld_val), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    m_act = 1'b0;
    m_age = 0;
    m_done_at = 0;
    m_rr = 0;
    m_val = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [N_REQ-1:0] r;
    logic [VW-1:0]    v;
    logic [VW-1:0]    w;

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_gnt", 32'(gnt), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_cnt_ld", 32'(cnt_ld), 32'd0);
    check("reset_cnt_ld_val", 32'(cnt_ld_val), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;

    // Single session, value C, one wrap.
    step(4'b0001, 16'h000C, 16'h0001);
    repeat (8) step('0, '0, '0);

    // All requesting from pointer 0: rotation 0,1,2,3,0,...
    do_reset();
    repeat (30) step(4'b1111, 16'hEEEE, 16'h1111);
    repeat (6) step('0, '0, '0);

    // Value F, three wraps: counter sits at F.
    step(4'b0010, 16'h00F0, 16'h0030);
    repeat (6) step('0, '0, '0);

    // Zero wraps treated as one.
    step(4'b0100, 16'h0E00, 16'h0000);
    repeat (5) step('0, '0, '0);

    // Reset during RUN; next grant restarts from requester 0.
    repeat (3) step(4'b0100, 16'h0000, 16'h0200);
    do_reset();
    step(4'b1111, 16'h9999, 16'h1111);
    repeat (10) step('0, '0, '0);

    // Request dropped mid-session; session still completes after second F.
    step(4'b0001, 16'h000D, 16'h0002);
    repeat (3) step('0, 16'h5555, 16'hFFFF);
    repeat (8) step('0, '0, '0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) r = '0;
      else r = N_REQ'($urandom);
      v = VW'($urandom);
      w = VW'($urandom) & 16'h3333;
      if ($urandom_range(0, 199) == 0) do_reset();
      step(r, v, w);
    end

    @(negedge clk);
    compare_outputs();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
